patternbuf_ctrl: RTL
====================

# patternbuf_ctrl

Controller that owns the control pins of the 32×8 pattern buffer and shares it between two requesters. The first is a serial loader that streams a full 256-bit pattern through the scan chain. The second is the processor's single-field write port. The controller guarantees that shift and field write are never asserted together, and that a started serial load always runs to completion or is explicitly aborted. It also returns the bits shifted out of the chain, which gives readback during a load.

## Interface
- BUF_WIDTH, 8, bits per field
- BUF_SIZE, 32, number of fields; TOTAL_BITS = BUF_WIDTH*BUF_SIZE = 256
- clk  in  1  single clock for the controller and the buffer
- rst_n  in  1  synchronous, active-low reset
- ld_start  in  1  one-cycle pulse: begin a serial load
- ld_abort  in  1  one-cycle pulse: end the load early
- sin_bit  in  1  next serial bit
- sin_valid  in  1  sin_bit is valid this cycle (LOAD only)
- ld_busy  out  1  high while in LOAD
- ld_done  out  1  one-cycle pulse after the final shift
- dout_bit  out  1  bit shifted out of the chain
- dout_valid  out  1  dout_bit valid
- wr_req  in  1  processor write request; held until acked
- wr_addr  in  5  field index
- wr_data  in  BUF_WIDTH  field data
- wr_ack  out  1  one-cycle pulse, write performed
- buf_ssel  out  1  buffer shift enable
- buf_sin  out  1  buffer serial input
- buf_sout  in  1  buffer serial output (MSB of last field)
- buf_fieldp  out  5  buffer field pointer
- buf_field_in  out  BUF_WIDTH  buffer write data
- buf_field_write  out  1  buffer field write strobe

## Operation
- States: IDLE, LOAD.
- All outputs are registered. Reset value of every output is 0; the state resets to IDLE and bit_cnt resets to 0.
- **IDLE**
  - ld_start=1 → LOAD, bit_cnt←0, ld_busy←1. ld_start wins over a simultaneous wr_req; that write waits.
  - Otherwise, if wr_req=1 and wr_ack was 0 the previous cycle, drive buf_field_write=1, buf_fieldp=wr_addr and buf_field_in=wr_data for one cycle, with wr_ack=1 in that same cycle.
  - The back-to-back guard means each request gets exactly one write per ack.
- **LOAD**
  - wr_req is never acked. buf_field_write is held at 0, and buf_fieldp and buf_field_in are held at 0.
  - Each sampled sin_valid=1 issues one shift cycle: buf_ssel=1 and buf_sin=sin_bit.
  - bit_cnt increments on each issued shift; it is 8 bits wide.
  - The shift issued with bit_cnt==TOTAL_BITS−1 is the last one. The cycle after it: ld_done=1, ld_busy=0, state→IDLE.
  - sin_valid gaps are allowed: the load stalls with buf_ssel=0.
  - ld_abort=1 → IDLE next cycle with ld_busy=0. No ld_done pulse is produced. Buffer contents are left partially shifted. ld_abort takes priority over a sin_valid in the same cycle, and that bit is not shifted.
  - ld_start in LOAD is ignored.
- **Readback**
  - In every cycle with buf_ssel=1, the controller captures buf_sout.
  - The next cycle: dout_bit=captured value, dout_valid=1.
  - Over a full load, dout returns the previous 256-bit content, MSB of field 31 first.
- Reset mid-load → IDLE immediately on the reset edge. No ld_done pulse and no pending ack is produced.
- Invariant: buf_ssel & buf_field_write == 0 in every cycle. Assert this in RTL.

## Timing
- Write latency: wr_req sampled high at edge N gives wr_ack and buf_field_write high in cycle N+1. The buffer captures the data at edge N+2. The earliest next write is cycle N+3.
- Shift latency: sin_valid sampled at edge N gives buf_ssel high in cycle N+1. The buffer shifts at edge N+2. dout_valid is high in cycle N+2.
- Full load with continuous sin_valid:
  - ld_start at edge 0 → ld_busy from cycle 1.
  - The first sin_valid is accepted at edge 1.
  - The 256 shifts occupy cycles 2–257.
  - ld_done is high in cycle 258.
  - A write pending since the load began is acked no earlier than cycle 259.

## Structure
- patternbuf_pkg: BUF_WIDTH, BUF_SIZE, TOTAL_BITS, ADDR_W=$clog2(BUF_SIZE), CNT_W=$clog2(TOTAL_BITS), and the state enum ctrl_state_t {IDLE, LOAD}.
- One natural sub-module: patternbuf_bitcnt, a loadable up-counter with a terminal-count flag, instantiated for bit_cnt.
- The top-level test harness instantiates patternbuf_ctrl driving patternbuf.

## Test plan
1. Reset, then wr_req with addr=5 and data=0xA5 → wr_ack is a single pulse; field 5 reads 0xA5 and all other fields are unchanged.
2. Continuous load of 256 bits, 0x01..0x20 per field → ld_done in cycle 258 and field k = k+1. A second load streams those values back on dout, MSB of field 31 first.
3. Load with sin_valid toggling every other cycle → exactly 256 buf_ssel cycles, and ld_done after the final one.
4. ld_start and wr_req in the same cycle → the load runs first. wr_ack fires only after ld_done, and the written field lands after the load data.
5. ld_abort after 100 shifts (and separately rst_n low at shift 100) → IDLE, no ld_done, a subsequent write is acked normally, and bit_cnt restarts at 0 on the next load.
6. Random stimulus for 10k cycles → buf_ssel & buf_field_write is never high together, and there is exactly one wr_ack per request.

Source files
------------

// File: rtl/patternbuf_pkg.sv
// Shared constants and types for the pattern buffer controller.
package patternbuf_pkg;

    localparam int BUF_WIDTH  = 8;
    localparam int BUF_SIZE   = 32;
    localparam int TOTAL_BITS = BUF_WIDTH * BUF_SIZE;
    localparam int ADDR_W     = $clog2(BUF_SIZE);
    localparam int CNT_W      = $clog2(TOTAL_BITS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } ctrl_state_t;

    // Count value that marks the final shift of a full-pattern load.
    function automatic logic [CNT_W-1:0] last_bit_index();
        return CNT_W'(TOTAL_BITS - 1);
    endfunction

endpackage

// File: rtl/patternbuf_bitcnt.sv
// Loadable up-counter with a terminal-count flag; tracks shifts in a load.
module patternbuf_bitcnt #(
    parameter int             W      = 8,
    parameter logic [W-1:0]   TC_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    // Counter register: load has priority over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (inc_i) begin
            cnt_q <= cnt_q + W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/patternbuf_ctrl.sv
// Arbiter/sequencer for the 32x8 pattern buffer: serial scan load versus
// single-field processor writes, plus readback of the bits shifted out.
module patternbuf_ctrl_chk
    import patternbuf_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    input logic             buf_ssel,
    input logic             buf_field_write,
    input logic             ld_done,
    input logic [CNT_W-1:0] bit_cnt
);

    // Shift and field write are mutually exclusive; a completed load has
    // wrapped the 8-bit counter back to zero.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(buf_ssel && buf_field_write));
            assert (!ld_done || (bit_cnt == '0));
        end
    end

endmodule

module patternbuf_ctrl
    import patternbuf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld_start,
    input  logic                 ld_abort,
    input  logic                 sin_bit,
    input  logic                 sin_valid,
    output logic                 ld_busy,
    output logic                 ld_done,
    output logic                 dout_bit,
    output logic                 dout_valid,
    input  logic                 wr_req,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [BUF_WIDTH-1:0] wr_data,
    output logic                 wr_ack,
    output logic                 buf_ssel,
    output logic                 buf_sin,
    input  logic                 buf_sout,
    output logic [ADDR_W-1:0]    buf_fieldp,
    output logic [BUF_WIDTH-1:0] buf_field_in,
    output logic                 buf_field_write
);

    ctrl_state_t          state_q;
    logic                 last_q;      // final shift issued, completion pending
    logic                 ld_busy_q;
    logic                 ld_done_q;
    logic                 dout_bit_q;
    logic                 dout_valid_q;
    logic                 wr_ack_q;
    logic                 buf_ssel_q;
    logic                 buf_sin_q;
    logic [ADDR_W-1:0]    buf_fieldp_q;
    logic [BUF_WIDTH-1:0] buf_field_in_q;
    logic                 buf_field_write_q;

    logic                 cnt_clr_s;
    logic                 shift_go_s;
    logic                 write_go_s;
    logic [CNT_W-1:0]     bit_cnt_s;
    logic                 bit_tc_s;

    // Decode this cycle's action from state and requests.
    always_comb begin
        cnt_clr_s  = 1'b0;
        shift_go_s = 1'b0;
        write_go_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    cnt_clr_s = 1'b1;
                end else if (wr_req && !wr_ack_q) begin
                    // wr_ack_q high means this request was just served.
                    write_go_s = 1'b1;
                end else begin
                    write_go_s = 1'b0;
                end
            end
            LOAD: begin
                // Abort wins over a valid bit; no shifts once the last is out.
                if (!ld_abort && !last_q && sin_valid) begin
                    shift_go_s = 1'b1;
                end else begin
                    shift_go_s = 1'b0;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    patternbuf_bitcnt #(
        .W      (CNT_W),
        .TC_VAL (last_bit_index())
    ) u_bitcnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_clr_s),
        .load_val_i ({CNT_W{1'b0}}),
        .inc_i      (shift_go_s),
        .cnt_o      (bit_cnt_s),
        .tc_o       (bit_tc_s)
    );

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            last_q            <= 1'b0;
            ld_busy_q         <= 1'b0;
            ld_done_q         <= 1'b0;
            dout_bit_q        <= 1'b0;
            dout_valid_q      <= 1'b0;
            wr_ack_q          <= 1'b0;
            buf_ssel_q        <= 1'b0;
            buf_sin_q         <= 1'b0;
            buf_fieldp_q      <= '0;
            buf_field_in_q    <= '0;
            buf_field_write_q <= 1'b0;
        end else begin
            // Readback: the bit leaving the chain during a shift cycle.
            dout_valid_q      <= buf_ssel_q;
            dout_bit_q        <= buf_ssel_q ? buf_sout : 1'b0;
            ld_done_q         <= 1'b0;
            wr_ack_q          <= 1'b0;
            buf_ssel_q        <= 1'b0;
            buf_sin_q         <= 1'b0;
            buf_fieldp_q      <= '0;
            buf_field_in_q    <= '0;
            buf_field_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cnt_clr_s) begin
                        state_q   <= LOAD;
                        ld_busy_q <= 1'b1;
                        last_q    <= 1'b0;
                    end else if (write_go_s) begin
                        buf_field_write_q <= 1'b1;
                        buf_fieldp_q      <= wr_addr;
                        buf_field_in_q    <= wr_data;
                        wr_ack_q          <= 1'b1;
                    end else begin
                        ld_busy_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ld_abort) begin
                        state_q   <= IDLE;
                        ld_busy_q <= 1'b0;
                        last_q    <= 1'b0;
                    end else if (last_q) begin
                        state_q   <= IDLE;
                        ld_busy_q <= 1'b0;
                        ld_done_q <= 1'b1;
                        last_q    <= 1'b0;
                    end else if (shift_go_s) begin
                        buf_ssel_q <= 1'b1;
                        buf_sin_q  <= sin_bit;
                        last_q     <= bit_tc_s;
                    end else begin
                        ld_busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ld_busy_q <= 1'b0;
                    last_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ld_busy         = ld_busy_q;
    assign ld_done         = ld_done_q;
    assign dout_bit        = dout_bit_q;
    assign dout_valid      = dout_valid_q;
    assign wr_ack          = wr_ack_q;
    assign buf_ssel        = buf_ssel_q;
    assign buf_sin         = buf_sin_q;
    assign buf_fieldp      = buf_fieldp_q;
    assign buf_field_in    = buf_field_in_q;
    assign buf_field_write = buf_field_write_q;

    patternbuf_ctrl_chk u_chk (
        .clk             (clk),
        .rst_n           (rst_n),
        .buf_ssel        (buf_ssel_q),
        .buf_field_write (buf_field_write_q),
        .ld_done         (ld_done_q),
        .bit_cnt         (bit_cnt_s)
    );

endmodule
